// File: rtl/io_uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets,
// STATUS bit positions and the TX/RX state encodings.
package io_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_TX_BUSY      = 2;
  localparam int ST_RX_VALID     = 3;
  localparam int ST_RX_OVERRUN   = 4;
  localparam int ST_RX_FRAME_ERR = 5;
  localparam int ST_TX_OVF       = 6;
  localparam int ST_TX_COUNT     = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and an
// occupancy count. Pushes into a full FIFO and pops from an empty one
// are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush, doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  // Storage array; written only on an accepted push, needs no reset.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      if (doPush && !doPop)      count_q <= count_q + CNT_W'(1);
      else if (doPop && !doPush) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/io_uart.sv
// Bus-mapped UART: decodes a 32-byte window, queues TX bytes in a FIFO
// and shifts them out as 8N1 frames, and receives 8N1 frames into a
// single holding register with sticky status flags.
module io_uart
  import io_uart_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR    = 64'hFFFF_0000_0000_0000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] addr,
  input  logic        addr_valid,
  input  logic        write,
  input  logic [63:0] data_in,
  output logic [63:0] data_out,
  output logic        ready,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);

  localparam int             CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int             BCW       = $clog2(CLKS_PER_BIT);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);

  logic             sel, wrPulse, write_q, unusedBits;
  logic [1:0]       regIdx;
  logic             ready_q, irq_q;
  logic [63:0]      dataOut_q, readWord, statusWord;
  logic             rxValid_q, rxOverrun_q, rxFrameErr_q, txOvf_q, txIe_q;
  logic [7:0]       rxByte_q;
  logic             txPush, txPop, txFull, txEmpty, txBusy, uartTxLine;
  logic [7:0]       txFifoData;
  logic [CNT_W-1:0] txCount;
  txState_e         txState_q, txState_d;
  logic [BCW-1:0]   txCnt_q, txCnt_d;
  logic [2:0]       txBit_q, txBit_d;
  logic [7:0]       txShift_q, txShift_d;
  logic             rxMeta_q, rxSync_q, rxPrev_q, rxLoad, rxBad;
  rxState_e         rxState_q, rxState_d;
  logic [BCW-1:0]   rxCnt_q, rxCnt_d;
  logic [2:0]       rxBit_q, rxBit_d;
  logic [7:0]       rxShift_q, rxShift_d;

  assign sel        = addr_valid & (addr[63:5] == BASE_ADDR[63:5]);
  assign regIdx     = addr[4:3];
  assign wrPulse    = sel & write & ~write_q;
  assign txPush     = wrPulse & (regIdx == REG_TXDATA);
  assign unusedBits = ^{addr[2:0], data_in[63:8]};
  assign data_out   = dataOut_q;
  assign ready      = ready_q;
  assign irq        = irq_q;
  assign uart_tx    = uartTxLine;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) uTxFifo (
    .clk(clk), .rst(rst), .push_i(txPush), .data_i(data_in[7:0]),
    .pop_i(txPop), .data_o(txFifoData), .count_o(txCount),
    .full_o(txFull), .empty_o(txEmpty)
  );

  // Assemble the STATUS word and select the register being read.
  always_comb begin
    statusWord                        = '0;
    statusWord[ST_TX_FULL]            = txFull;
    statusWord[ST_TX_EMPTY]           = txEmpty;
    statusWord[ST_TX_BUSY]            = txBusy;
    statusWord[ST_RX_VALID]           = rxValid_q;
    statusWord[ST_RX_OVERRUN]         = rxOverrun_q;
    statusWord[ST_RX_FRAME_ERR]       = rxFrameErr_q;
    statusWord[ST_TX_OVF]             = txOvf_q;
    statusWord[ST_TX_COUNT +: CNT_W]  = txCount;
    case (regIdx)
      REG_RXDATA: readWord = {56'b0, rxByte_q};
      REG_STATUS: readWord = statusWord;
      REG_CTRL:   readWord = {63'b0, txIe_q};
      default:    readWord = '0;
    endcase
  end

  // Bus response, interrupt and register flags. Clears are written first
  // so that a same-cycle hardware set overrides a CPU clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q      <= 1'b0;
      ready_q      <= 1'b0;
      dataOut_q    <= '0;
      irq_q        <= 1'b0;
      rxValid_q    <= 1'b0;
      rxOverrun_q  <= 1'b0;
      rxFrameErr_q <= 1'b0;
      txOvf_q      <= 1'b0;
      txIe_q       <= 1'b0;
      rxByte_q     <= '0;
    end else begin
      write_q   <= write;
      ready_q   <= sel;
      dataOut_q <= sel ? readWord : '0;
      irq_q     <= rxValid_q | (txEmpty & txIe_q);
      if (wrPulse && regIdx == REG_RXDATA) rxValid_q <= 1'b0;
      if (wrPulse && regIdx == REG_CTRL) begin
        txIe_q <= data_in[0];
        if (data_in[ST_RX_OVERRUN])   rxOverrun_q  <= 1'b0;
        if (data_in[ST_RX_FRAME_ERR]) rxFrameErr_q <= 1'b0;
        if (data_in[ST_TX_OVF])       txOvf_q      <= 1'b0;
      end
      if (txPush && txFull) txOvf_q <= 1'b1;
      if (rxBad) rxFrameErr_q <= 1'b1;
      if (rxLoad) begin
        rxByte_q  <= rxShift_q;
        rxValid_q <= 1'b1;
        if (rxValid_q) rxOverrun_q <= 1'b1;
      end
    end
  end

  // TX state register and bit-timing datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txState_q <= TX_IDLE;
      txCnt_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
    end else begin
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txBit_q   <= txBit_d;
      txShift_q <= txShift_d;
    end
  end

  // TX next state: each phase lasts CLKS_PER_BIT cycles, data LSB first.
  always_comb begin
    txState_d = txState_q;
    txCnt_d   = txCnt_q + BCW'(1);
    txBit_d   = txBit_q;
    txShift_d = txShift_q;
    case (txState_q)
      TX_IDLE: begin
        txCnt_d = '0;
        if (!txEmpty) begin
          txState_d = TX_START;
          txShift_d = txFifoData;
        end
      end
      TX_START: if (txCnt_q == BIT_LAST) begin
        txState_d = TX_DATA;
        txCnt_d   = '0;
        txBit_d   = '0;
      end
      TX_DATA: if (txCnt_q == BIT_LAST) begin
        txCnt_d   = '0;
        txShift_d = {1'b0, txShift_q[7:1]};
        if (txBit_q == 3'd7) txState_d = TX_STOP;
        else                 txBit_d   = txBit_q + 3'd1;
      end
      TX_STOP: if (txCnt_q == BIT_LAST) begin
        txState_d = TX_IDLE;
        txCnt_d   = '0;
      end
      default: txState_d = TX_IDLE;
    endcase
  end

  // TX outputs: line level, busy flag and FIFO pop while idle.
  always_comb begin
    txPop      = 1'b0;
    txBusy     = 1'b1;
    uartTxLine = 1'b1;
    case (txState_q)
      TX_IDLE: begin
        txBusy = 1'b0;
        txPop  = ~txEmpty;
      end
      TX_START: uartTxLine = 1'b0;
      TX_DATA:  uartTxLine = txShift_q[0];
      default:  uartTxLine = 1'b1;
    endcase
  end

  // RX synchroniser, edge-history flop and RX state register. The line
  // idles high, so the synchroniser resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta_q  <= 1'b1;
      rxSync_q  <= 1'b1;
      rxPrev_q  <= 1'b1;
      rxState_q <= RX_IDLE;
      rxCnt_q   <= '0;
      rxBit_q   <= '0;
      rxShift_q <= '0;
    end else begin
      rxMeta_q  <= uart_rx;
      rxSync_q  <= rxMeta_q;
      rxPrev_q  <= rxSync_q;
      rxState_q <= rxState_d;
      rxCnt_q   <= rxCnt_d;
      rxBit_q   <= rxBit_d;
      rxShift_q <= rxShift_d;
    end
  end

  // RX next state: half a bit to the start-bit centre, then whole bits.
  always_comb begin
    rxState_d = rxState_q;
    rxCnt_d   = rxCnt_q + BCW'(1);
    rxBit_d   = rxBit_q;
    rxShift_d = rxShift_q;
    case (rxState_q)
      RX_IDLE: begin
        rxCnt_d = '0;
        if (rxPrev_q && !rxSync_q) rxState_d = RX_START;
      end
      RX_START: if (rxCnt_q == HALF_LAST) begin
        rxCnt_d   = '0;
        rxBit_d   = '0;
        rxState_d = rxSync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rxCnt_q == BIT_LAST) begin
        rxCnt_d   = '0;
        rxShift_d = {rxSync_q, rxShift_q[7:1]};
        if (rxBit_q == 3'd7) rxState_d = RX_STOP;
        else                 rxBit_d   = rxBit_q + 3'd1;
      end
      RX_STOP: if (rxCnt_q == BIT_LAST) begin
        rxCnt_d   = '0;
        rxState_d = RX_IDLE;
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  // RX outputs: stop-bit verdict at its centre sample.
  always_comb begin
    rxLoad = 1'b0;
    rxBad  = 1'b0;
    if (rxState_q == RX_STOP && rxCnt_q == BIT_LAST) begin
      rxLoad = rxSync_q;
      rxBad  = ~rxSync_q;
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Directed testbench for io_uart with a 4-cycle bit time.
module tb_io_uart;
  import io_uart_pkg::*;

  localparam logic [63:0] BASE = 64'hFFFF_0000_0000_0000;
  localparam int          CPB  = 4;

  logic        clk, rst, addr_valid, write, uart_rx, ready, uart_tx, irq;
  logic [63:0] addr, data_in, data_out;
  int          checkCount = 0;
  int          passCount  = 0;

  io_uart #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .addr_valid(addr_valid),
    .write(write), .data_in(data_in), .data_out(data_out), .ready(ready),
    .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] regAddr(input logic [1:0] idx);
    return BASE | {59'b0, idx, 3'b000};
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    else
      passCount++;
  endtask

  // One bus write with the strobe held for 'hold' cycles.
  task automatic applyStimulus(input logic [1:0] idx, input logic [63:0] wdata,
                               input int hold);
    @(negedge clk);
    addr       = regAddr(idx);
    addr_valid = 1'b1;
    write      = 1'b1;
    data_in    = wdata;
    repeat (hold) @(negedge clk);
    addr_valid = 1'b0;
    write      = 1'b0;
    data_in    = '0;
  endtask

  // One-cycle read; low address bits are set to show they are ignored.
  task automatic checkReg(input string tag, input logic [1:0] idx,
                          input logic [63:0] expected);
    @(negedge clk);
    addr       = regAddr(idx) | 64'h5;
    addr_valid = 1'b1;
    write      = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_ready"}, 64'(ready), 64'd1);
    checkOutput(tag, data_out, expected);
    addr_valid = 1'b0;
  endtask

  // Drive one 8N1 frame on uart_rx, then allow time for the receiver.
  task automatic sendRxFrame(input logic [7:0] b, input logic stopBit);
    logic [9:0] f;
    f = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rx = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [9:0]  frameBits;
    logic [49:0] expWave, obsWave;

    rst = 1'b1; addr = '0; addr_valid = 1'b0; write = 1'b0;
    data_in = '0; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rstUartTx", 64'(uart_tx), 64'd1);
    checkOutput("rstReady", 64'(ready), 64'd0);
    checkOutput("rstDataOut", data_out, 64'd0);
    checkOutput("rstIrq", 64'(irq), 64'd0);
    rst = 1'b0;

    $display("[TB] reset state and read timing");
    @(negedge clk);
    addr       = regAddr(REG_STATUS);
    addr_valid = 1'b1;
    checkOutput("readyBeforeEdge", 64'(ready), 64'd0);
    @(negedge clk);
    checkOutput("readyRise", 64'(ready), 64'd1);
    checkOutput("statusAfterReset", data_out, 64'h002);
    addr_valid = 1'b0;
    @(negedge clk);
    checkOutput("readyFall", 64'(ready), 64'd0);
    addr       = BASE + 64'h20;
    addr_valid = 1'b1;
    @(negedge clk);
    checkOutput("readyOutsideWindow", 64'(ready), 64'd0);
    addr_valid = 1'b0;

    $display("[TB] single TX frame with held strobe");
    frameBits = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 50; k++)
      expWave[k] = (k < 2 || k >= 42) ? 1'b1 : frameBits[(k - 2) / 4];
    @(negedge clk);
    addr = regAddr(REG_TXDATA); addr_valid = 1'b1; write = 1'b1; data_in = 64'hA5;
    obsWave[0] = uart_tx;
    for (int k = 1; k < 50; k++) begin
      @(negedge clk);
      if (k == 3) begin
        addr_valid = 1'b0; write = 1'b0; data_in = '0;
      end
      obsWave[k] = uart_tx;
    end
    checkOutput("txFrameA5", 64'(obsWave), 64'(expWave));
    checkReg("statusAfterFrame", REG_STATUS, 64'h002);

    $display("[TB] FIFO fill and overflow");
    for (int i = 0; i < 10; i++) applyStimulus(REG_TXDATA, 64'(8'h10 + i), 1);
    checkReg("statusFull", REG_STATUS, 64'h845);
    applyStimulus(REG_CTRL, 64'h40, 1);
    checkReg("statusOvfCleared", REG_STATUS, 64'h805);
    checkReg("ctrlAfterClear", REG_CTRL, 64'h0);
    checkReg("txdataReadsZero", REG_TXDATA, 64'h0);
    repeat (400) @(negedge clk);
    checkReg("statusDrained", REG_STATUS, 64'h002);

    $display("[TB] RX frames");
    sendRxFrame(8'h3C, 1'b1);
    checkReg("rxData3C", REG_RXDATA, 64'h3C);
    checkReg("statusRxValid", REG_STATUS, 64'h00A);
    checkOutput("irqRxValid", 64'(irq), 64'd1);
    sendRxFrame(8'h7E, 1'b1);
    checkReg("statusOverrun", REG_STATUS, 64'h01A);
    checkReg("rxData7E", REG_RXDATA, 64'h7E);
    sendRxFrame(8'h55, 1'b0);
    checkReg("statusFrameErr", REG_STATUS, 64'h03A);
    checkReg("rxDataKept", REG_RXDATA, 64'h7E);
    @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    checkReg("statusAfterGlitch", REG_STATUS, 64'h03A);
    applyStimulus(REG_CTRL, 64'h70, 1);
    checkReg("statusStickyCleared", REG_STATUS, 64'h00A);
    applyStimulus(REG_RXDATA, 64'h0, 1);
    checkReg("statusRxCleared", REG_STATUS, 64'h002);
    checkOutput("irqAfterRxClear", 64'(irq), 64'd0);

    $display("[TB] TX interrupt enable and reset mid-frame");
    applyStimulus(REG_CTRL, 64'h1, 1);
    @(negedge clk);
    checkOutput("irqTxEmpty", 64'(irq), 64'd1);
    applyStimulus(REG_TXDATA, 64'h00, 1);
    applyStimulus(REG_TXDATA, 64'h00, 1);
    repeat (6) @(negedge clk);
    checkOutput("txMidFrame", 64'(uart_tx), 64'd0);
    checkOutput("irqTxPending", 64'(irq), 64'd0);
    rst = 1'b1;
    #1;
    checkOutput("txAfterReset", 64'(uart_tx), 64'd1);
    checkOutput("irqAfterReset", 64'(irq), 64'd0);
    checkOutput("dataOutAfterReset", data_out, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    checkReg("statusAfterMidReset", REG_STATUS, 64'h002);
    checkReg("ctrlAfterMidReset", REG_CTRL, 64'h0);
    repeat (10) @(negedge clk);
    checkOutput("txIdleAfterReset", 64'(uart_tx), 64'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
